// File: rtl/alu_8bit.sv
// Registered single-cycle integer ALU: WIDTH-bit operands, 4-bit opcode, result plus zero and carry/borrow flags.
// Build option ALU_SIGNED_OVF_EN: ADD/SUB/INC/DEC report two's-complement signed overflow instead of carry/borrow.
module alu_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             overflow_flag
);

    localparam int               MSB     = WIDTH - 1;
    localparam logic [WIDTH-1:0] ZERO_V  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_V  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_CMP   = 4'd7;
    localparam logic [3:0] OP_NOT   = 4'd8;
    localparam logic [3:0] OP_INC   = 4'd9;
    localparam logic [3:0] OP_DEC   = 4'd10;
    localparam logic [3:0] OP_ASR   = 4'd11;
    localparam logic [3:0] OP_ROL   = 4'd12;
    localparam logic [3:0] OP_ROR   = 4'd13;
    localparam logic [3:0] OP_PASSA = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   add_s, sub_s, inc_s, dec_s;
    logic             big_shift_s;
    logic [WIDTH-1:0] rot_amt_s, rol_s, ror_s, asr_s;

    assign add_s       = {1'b0, a} + {1'b0, b};
    assign sub_s       = {1'b0, a} - {1'b0, b};
    assign inc_s       = {1'b0, a} + {1'b0, ONE_V};
    assign dec_s       = {1'b0, a} - {1'b0, ONE_V};
    assign big_shift_s = (b >= WIDTH_V);
    assign rot_amt_s   = b % WIDTH_V;
    // A shift by the full width yields zero, so rotate-by-0 falls out without a special case.
    assign rol_s       = (a << rot_amt_s) | (a >> (WIDTH_V - rot_amt_s));
    assign ror_s       = (a >> rot_amt_s) | (a << (WIDTH_V - rot_amt_s));
    assign asr_s       = $signed(a) >>> b;

    // Next result and overflow for the selected operation.
    always_comb begin
        result_d = ZERO_V;
        ovf_d    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result_d = add_s[WIDTH-1:0];
`ifdef ALU_SIGNED_OVF_EN
                ovf_d = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
`else
                ovf_d = add_s[WIDTH];
`endif
            end
            OP_SUB: begin
                result_d = sub_s[WIDTH-1:0];
`ifdef ALU_SIGNED_OVF_EN
                ovf_d = (a[MSB] != b[MSB]) && (sub_s[MSB] != a[MSB]);
`else
                ovf_d = sub_s[WIDTH];
`endif
            end
            OP_AND:   result_d = a & b;
            OP_OR:    result_d = a | b;
            OP_XOR:   result_d = a ^ b;
            OP_SHL: begin
                if (big_shift_s) result_d = ZERO_V;
                else             result_d = a << b;
            end
            OP_SHR: begin
                if (big_shift_s) result_d = ZERO_V;
                else             result_d = a >> b;
            end
            OP_CMP: begin
                if (a > b)       result_d = ONE_V;
                else if (a == b) result_d = ZERO_V;
                else             result_d = ONES_V;
            end
            OP_NOT:   result_d = ~a;
            OP_INC: begin
                result_d = inc_s[WIDTH-1:0];
`ifdef ALU_SIGNED_OVF_EN
                ovf_d = ~a[MSB] & inc_s[MSB];
`else
                ovf_d = inc_s[WIDTH];
`endif
            end
            OP_DEC: begin
                result_d = dec_s[WIDTH-1:0];
`ifdef ALU_SIGNED_OVF_EN
                ovf_d = a[MSB] & ~dec_s[MSB];
`else
                ovf_d = dec_s[WIDTH];
`endif
            end
            OP_ASR: begin
                if (big_shift_s) result_d = {WIDTH{a[MSB]}};
                else             result_d = asr_s;
            end
            OP_ROL:   result_d = rol_s;
            OP_ROR:   result_d = ror_s;
            OP_PASSA: result_d = a;
            OP_PASSB: result_d = b;
            default: begin
                result_d = ZERO_V;
                ovf_d    = 1'b0;
            end
        endcase
    end

    // Zero flag derived from the same next value so it lands with its result.
    always_comb begin
        zero_d = (result_d == ZERO_V);
    end

    // Output registers; reset clears them without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= ZERO_V;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result        = result_q;
    assign zero_flag     = zero_q;
    assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: directed vectors push expectations, a monitor pops one per issued op.
module tb_alu_8bit;

`ifdef ALU_SIGNED_OVF_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND_ = 4'd2, OR_ = 4'd3;
    localparam logic [3:0] XOR_ = 4'd4, SHL = 4'd5,  SHR = 4'd6,  CMP = 4'd7;
    localparam logic [3:0] NOT_ = 4'd8, INC = 4'd9,  DEC = 4'd10, ASR = 4'd11;
    localparam logic [3:0] ROL = 4'd12, ROR = 4'd13, PSA = 4'd14, PSB = 4'd15;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       o;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a_s, b_s;
    logic [3:0] op_s;
    logic [7:0] result;
    logic       zero_flag, overflow_flag;
    logic       in_valid;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_8bit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a_s), .b(b_s), .opcode(op_s),
        .result(result), .zero_flag(zero_flag), .overflow_flag(overflow_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_out(input string nm, input logic [7:0] er, input logic ez, input logic eo);
        n_tests++;
        if (result !== er || zero_flag !== ez || overflow_flag !== eo) begin
            n_fail++;
            $display("FAIL %s: got res=%h z=%b o=%b, want res=%h z=%b o=%b",
                     nm, result, zero_flag, overflow_flag, er, ez, eo);
        end
    endtask

    // Monitor: every op sampled out of reset produces one output one edge later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (in_valid === 1'b1 && rst_n === 1'b1) begin
                #1;
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got res=%h with no expected entry", result);
                end else begin
                    e = sbq.pop_front();
                    check_out(e.name, e.res, e.z, e.o);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] er, input logic ez, input logic eo, input string nm);
        exp_t e;
        @(negedge clk);
        a_s      = ia;
        b_s      = ib;
        op_s     = op;
        in_valid = 1'b1;
        e.res  = er;
        e.z    = ez;
        e.o    = eo;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a_s      = 8'h00;
        b_s      = 8'h00;
        op_s     = 4'd0;
        #2;
        a_s   = 8'($urandom);
        b_s   = 8'($urandom);
        op_s  = 4'($urandom);
        rst_n = 1'b0;
        #1;
        check_out("reset_async", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_held_edge", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(ADD,  8'h35, 8'h42, 8'h77, 1'b0, 1'b0,        "add_35_42");
        issue(ADD,  8'hFF, 8'h02, 8'h01, 1'b0, !SGN,        "add_ff_02");
        issue(SUB,  8'h50, 8'h20, 8'h30, 1'b0, 1'b0,        "sub_50_20");
        issue(SUB,  8'h20, 8'h50, 8'hD0, 1'b0, !SGN,        "sub_20_50");
        issue(INC,  8'hFF, 8'h00, 8'h00, 1'b1, !SGN,        "inc_ff");
        issue(AND_, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0,        "and_f0_0f");
        issue(OR_,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0,        "or_f0_0f");
        issue(XOR_, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0,        "xor_ff_0f");
        issue(NOT_, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0,        "not_5a");
        issue(SHL,  8'h01, 8'h02, 8'h04, 1'b0, 1'b0,        "shl_01_2");
        issue(SHR,  8'h80, 8'h02, 8'h20, 1'b0, 1'b0,        "shr_80_2");
        issue(ASR,  8'h80, 8'h02, 8'hE0, 1'b0, 1'b0,        "asr_80_2");
        issue(SHL,  8'h01, 8'h09, 8'h00, 1'b1, 1'b0,        "shl_01_9");
        issue(SHL,  8'h03, 8'h07, 8'h80, 1'b0, 1'b0,        "shl_03_7");
        issue(SHR,  8'h80, 8'h08, 8'h00, 1'b1, 1'b0,        "shr_80_8");
        issue(ASR,  8'h80, 8'h09, 8'hFF, 1'b0, 1'b0,        "asr_80_9");
        issue(ASR,  8'h40, 8'h09, 8'h00, 1'b1, 1'b0,        "asr_40_9");
        issue(ROL,  8'h81, 8'h01, 8'h03, 1'b0, 1'b0,        "rol_81_1");
        issue(ROL,  8'h81, 8'h08, 8'h81, 1'b0, 1'b0,        "rol_81_8");
        issue(ROR,  8'h01, 8'h09, 8'h80, 1'b0, 1'b0,        "ror_01_9");
        issue(ROR,  8'h01, 8'h03, 8'h20, 1'b0, 1'b0,        "ror_01_3");
        issue(CMP,  8'h80, 8'h20, 8'h01, 1'b0, 1'b0,        "cmp_gt");
        issue(CMP,  8'h20, 8'h20, 8'h00, 1'b1, 1'b0,        "cmp_eq");
        issue(CMP,  8'h10, 8'h20, 8'hFF, 1'b0, 1'b0,        "cmp_lt");
        issue(DEC,  8'h00, 8'h00, 8'hFF, 1'b0, !SGN,        "dec_00");
        issue(DEC,  8'h80, 8'h00, 8'h7F, 1'b0, SGN,         "dec_80");
        issue(INC,  8'h7F, 8'h00, 8'h80, 1'b0, SGN,         "inc_7f");
        issue(ADD,  8'h7F, 8'h01, 8'h80, 1'b0, SGN,         "add_7f_01");
        issue(SUB,  8'h80, 8'h01, 8'h7F, 1'b0, SGN,         "sub_80_01");
        issue(PSA,  8'h5A, 8'hC3, 8'h5A, 1'b0, 1'b0,        "passa_5a");
        // Opcode changes every cycle with no bubbles.
        issue(ADD,  8'h10, 8'h20, 8'h30, 1'b0, 1'b0,        "b2b_add");
        issue(SUB,  8'h30, 8'h10, 8'h20, 1'b0, 1'b0,        "b2b_sub");
        issue(CMP,  8'h05, 8'h06, 8'hFF, 1'b0, 1'b0,        "b2b_cmp");
        issue(PSB,  8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0,        "b2b_passb");

        // Reset mid-stream: outputs clear at once and the op pending at the edge is dropped.
        @(negedge clk);
        a_s      = 8'h11;
        b_s      = 8'hC3;
        op_s     = PSB;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("midstream_reset_async", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("midstream_reset_discard", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(ADD,  8'h35, 8'h42, 8'h77, 1'b0, 1'b0,        "add_after_reset");
        idle();
        repeat (3) @(negedge clk);

        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- Registered single-cycle integer ALU: two WIDTH-bit operands, 4-bit opcode, WIDTH-bit result, zero and overflow/carry flags.
- Inputs are sampled on each rising clock edge. Result and flags are registered outputs.
- Used as the datapath execution unit; there is no handshake, and a new operation can be issued every cycle.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; also the shift/rotate amount.
- opcode  input  4  operation select.
- result  output  WIDTH  registered operation result.
- zero_flag  output  1  registered; 1 when the registered result is all zeros.
- overflow_flag  output  1  registered; carry/borrow indicator (see below).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, result=0, zero_flag=0, overflow_flag=0 immediately, with no clock edge needed. Reset asserted mid-operation discards the pending result.
- Latency: operands and opcode sampled at edge N; result and both flags valid after edge N and held until the next edge. Throughput is 1 op/cycle.
- All arithmetic is unsigned and modulo 2^WIDTH.
- Opcode map:
  - 0 ADD: a+b; overflow_flag = carry out.
  - 1 SUB: a-b; overflow_flag = borrow (a<b).
  - 2 AND: a&b.
  - 3 OR: a|b.
  - 4 XOR: a^b.
  - 5 SHL: logical a<<b; result=0 if b>=WIDTH.
  - 6 SHR: logical a>>b; result=0 if b>=WIDTH.
  - 7 CMP (unsigned): result=1 if a>b, 0 if a==b, all-ones if a<b.
  - 8 NOT: ~a.
  - 9 INC: a+1; overflow_flag = carry out (a all-ones).
  - 10 DEC: a-1; overflow_flag = borrow (a==0).
  - 11 ASR: arithmetic a>>>b; b>=WIDTH fills the result with a[MSB].
  - 12 ROL: rotate a left by b mod WIDTH.
  - 13 ROR: rotate a right by b mod WIDTH.
  - 14 PASSA: result=a.
  - 15 PASSB: result=b.
- overflow_flag is 0 for every opcode not listed above as driving it.
- zero_flag is computed from the next result value and registered at the same edge as result, so it is never one cycle stale.
- Opcode changes every cycle must be honoured without bubbles.
- No X propagation: every opcode value produces a defined result.

Optional Feature:
- Macro: ALU_SIGNED_OVF_EN.
- Defined: for ADD, SUB, INC and DEC, overflow_flag reports two's-complement signed overflow instead of carry/borrow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have differing signs and the result sign differs from a.
  - INC: a = 0x7F (WIDTH=8).
  - DEC: a = 0x80 (WIDTH=8).
- Not defined: carry/borrow semantics as in Behaviour. result and zero_flag are identical in both builds.

Test Plan:
- Reset: rst_n=0 with random a, b, opcode, no clock -> result=00, zero_flag=0, overflow_flag=0 immediately. Release, then ADD 35+42 -> result 77, zero 0, overflow 0 one edge later.
- Arithmetic:
  - ADD FF+02 -> result 01, overflow 1 (carry build).
  - SUB 50-20 -> 30, overflow 0.
  - SUB 20-50 -> D0, overflow 1.
  - INC FF -> 00, zero 1, overflow 1.
- Logic:
  - AND F0&0F -> 00, zero 1.
  - OR F0|0F -> FF.
  - XOR FF^0F -> F0.
  - NOT 5A -> A5.
- Shifts:
  - SHL 01 by 2 -> 04.
  - SHR 80 by 2 -> 20.
  - ASR 80 by 2 -> E0.
  - SHL 01 by 09 -> 00, zero 1.
  - ROL 81 by 1 -> 03.
  - ROR 01 by 9 -> 80.
- Compare:
  - CMP 80,20 -> 01.
  - CMP 20,20 -> 00, zero 1.
  - CMP 10,20 -> FF, overflow 0.
- Back-to-back: change opcode every cycle (ADD, SUB, CMP, PASSB 3C) -> each result appears exactly one edge after its inputs. Asserting rst_n mid-stream clears outputs asynchronously. With ALU_SIGNED_OVF_EN defined, ADD 7F+01 -> 80, overflow 1, and ADD FF+02 -> 01, overflow 0.
